// File: rtl/mux_pkg.sv
// Shared constants for the N:1 stream multiplexer: mode encoding and output-stage states.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after last_grant, wrapping modulo N_CH.
module rr_arbiter #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last_grant,
    input  logic             enable,
    output logic [N_CH-1:0]  grant
);

    logic found;

    // Scan distances 1..N_CH from last_grant; compare against constant indices so no variable selects are needed.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned d = 1; d <= N_CH; d++) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (enable && !found && req[i] && (i == (32'(last_grant) + d) % N_CH)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_stream_rr.sv
// N:1 valid/ready stream multiplexer with fixed-select or round-robin arbitration and one output register.
module mux_stream_rr
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned N_CH  = 4,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_ch
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_d;
    logic [SEL_W-1:0]   ch_d;
    logic [SEL_W-1:0]   last_grant_q, last_grant_d;
    logic [N_CH-1:0]    rr_grant, fixed_grant, grant;
    logic               can_load, xfer;
    logic [SEL_W-1:0]   g_idx;
    logic [WIDTH-1:0]   g_data;

    rr_arbiter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_rr (
        .req        (in_valid),
        .last_grant (last_grant_q),
        .enable     (mode == MODE_RR),
        .grant      (rr_grant)
    );

    // Fixed-select grant; an out-of-range sel matches no channel and so grants nothing.
    always_comb begin
        fixed_grant = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (32'(sel) == i) fixed_grant[i] = in_valid[i];
        end
    end

    assign grant     = (mode == MODE_RR) ? rr_grant : fixed_grant;
    assign out_valid = (state_q == ST_FULL);
    assign can_load  = ~out_valid | out_ready;
    // Gating with reset_n keeps any handshake from completing on a reset edge.
    assign in_ready  = grant & {N_CH{can_load & reset_n}};
    assign xfer      = |in_ready;

    always_comb begin
        g_idx  = '0;
        g_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                g_idx  = SEL_W'(i);
                g_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        data_d       = out_data;
        ch_d         = out_ch;
        last_grant_d = last_grant_q;
        if (xfer) begin
            data_d       = g_data;
            ch_d         = g_idx;
            last_grant_d = g_idx;
        end
        case (state_q)
            ST_EMPTY: if (xfer) state_d = ST_FULL;
            ST_FULL:  if (!xfer && out_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_EMPTY;
            out_data     <= '0;
            out_ch       <= '0;
            last_grant_q <= SEL_W'(N_CH - 1);
        end else begin
            state_q      <= state_d;
            out_data     <= data_d;
            out_ch       <= ch_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_mux_stream_rr.sv
// Bench for mux_stream_rr: vector table with scoreboard on a 4-channel instance, plus a 3-channel wrap sequence.
module tb_mux_stream_rr;

    typedef struct {
        logic        rst_n;
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic        ordy;
        logic [3:0]  exp_ready;
        logic [15:0] data;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        logic [1:0] ch;
    } word_t;

    logic        clk = 1'b0;
    logic        reset_n, mode, out_ready, out_valid;
    logic [1:0]  sel, out_ch;
    logic [15:0] in_data;
    logic [3:0]  in_valid, in_ready, out_data;

    logic        reset_n_b, mode_b, out_ready_b, out_valid_b;
    logic [1:0]  sel_b, out_ch_b;
    logic [11:0] in_data_b;
    logic [2:0]  in_valid_b, in_ready_b;
    logic [3:0]  out_data_b;

    int checks = 0;
    int errors = 0;
    vec_t  vecs[$];
    word_t sb[$];

    always #5 clk = ~clk;

    mux_stream_rr #(.WIDTH(4), .N_CH(4)) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
    );

    mux_stream_rr #(.WIDTH(4), .N_CH(3)) dut_b (
        .clk(clk), .reset_n(reset_n_b), .mode(mode_b), .sel(sel_b),
        .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_ch(out_ch_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic m, input logic [1:0] s, input logic [3:0] v,
                       input logic o, input logic [3:0] er);
        vec_t t;
        t.rst_n = r; t.mode = m; t.sel = s; t.valid = v; t.ordy = o; t.exp_ready = er;
        t.data  = 16'hDA73 + 16'(vecs.size()) * 16'h1357;
        vecs.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input int row);
        check($sformatf("out_valid[%0d]", row), 32'(out_valid), 32'(sb.size() > 0));
        if (sb.size() > 0) begin
            check($sformatf("out_data[%0d]", row), 32'(out_data), 32'(sb[0].data));
            check($sformatf("out_ch[%0d]", row), 32'(out_ch), 32'(sb[0].ch));
        end
    endtask

    initial begin
        word_t w;
        reset_n = 1'b0; mode = 1'b1; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1; in_data = 16'h0;
        reset_n_b = 1'b0; mode_b = 1'b1; sel_b = 2'd0; in_valid_b = 3'b000; out_ready_b = 1'b1; in_data_b = 12'h0;

        // Reset with every channel valid
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_ch", 32'(out_ch), 32'h0);

        //   rst mode sel valid    ordy exp_ready
        add(1, 0, 2, 4'b1111, 1, 4'b0100);   // fixed sel=2, ch2 data A
        add(1, 0, 1, 4'b1111, 1, 4'b0010);   // fixed sel=1
        add(1, 1, 0, 4'b1111, 1, 4'b0100);   // switch to RR resumes after ch1
        add(1, 1, 0, 4'b1111, 1, 4'b1000);
        add(0, 1, 0, 4'b1111, 1, 4'b0000);   // reset while FULL
        add(1, 1, 0, 4'b1111, 1, 4'b0001);   // RR 0,1,2,3,0
        add(1, 1, 0, 4'b1111, 1, 4'b0010);
        add(1, 1, 0, 4'b1111, 1, 4'b0100);
        add(1, 1, 0, 4'b1111, 1, 4'b1000);
        add(1, 1, 0, 4'b1111, 1, 4'b0001);
        add(1, 1, 0, 4'b1010, 1, 4'b0010);   // RR 1,3,1,3
        add(1, 1, 0, 4'b1010, 1, 4'b1000);
        add(1, 1, 0, 4'b1010, 1, 4'b0010);
        add(1, 1, 0, 4'b1010, 1, 4'b1000);
        add(1, 1, 0, 4'b1010, 1, 4'b0010);   // FULL with ch1
        add(1, 1, 0, 4'b1010, 0, 4'b0000);   // backpressure x3
        add(1, 1, 0, 4'b1010, 0, 4'b0000);
        add(1, 1, 0, 4'b1010, 0, 4'b0000);
        add(1, 1, 0, 4'b1010, 1, 4'b1000);   // pop + push same edge
        add(1, 0, 0, 4'b0000, 1, 4'b0000);   // drain
        add(1, 0, 0, 4'b0001, 0, 4'b0001);   // EMPTY loads regardless of out_ready
        add(1, 0, 0, 4'b0001, 0, 4'b0000);
        add(1, 0, 3, 4'b1111, 1, 4'b1000);
        add(1, 0, 0, 4'b0000, 1, 4'b0000);
        add(1, 0, 0, 4'b0000, 1, 4'b0000);

        sb.delete();
        foreach (vecs[i]) begin
            check_outputs(i);
            reset_n = vecs[i].rst_n; mode = vecs[i].mode; sel = vecs[i].sel;
            in_valid = vecs[i].valid; out_ready = vecs[i].ordy; in_data = vecs[i].data;
            #1;
            check($sformatf("in_ready[%0d]", i), 32'(in_ready), 32'(vecs[i].exp_ready));
            if (!vecs[i].rst_n) begin
                sb.delete();
            end else begin
                if (sb.size() > 0 && vecs[i].ordy) void'(sb.pop_front());
                for (int c = 0; c < 4; c++) begin
                    if (vecs[i].exp_ready[c]) begin
                        w.data = vecs[i].data[c*4 +: 4];
                        w.ch   = 2'(c);
                        sb.push_back(w);
                    end
                end
            end
            tick();
        end
        check_outputs(vecs.size());
        check("sb_depth", 32'(sb.size()), 32'h0);

        // Three-channel instance: wrap from last_grant=2 and out-of-range sel
        reset_n = 1'b1;
        in_valid = 4'b0000;
        tick();
        reset_n_b = 1'b1; mode_b = 1'b1; in_valid_b = 3'b111; in_data_b = 12'h5C9;
        #1;
        check("b_wrap_ready", 32'(in_ready_b), 32'h1);
        tick();
        check("b_wrap_valid", 32'(out_valid_b), 32'h1);
        check("b_wrap_ch", 32'(out_ch_b), 32'h0);
        check("b_wrap_data", 32'(out_data_b), 32'h9);
        in_valid_b = 3'b100;
        #1;
        check("b_rr_ready", 32'(in_ready_b), 32'h4);
        tick();
        check("b_rr_ch", 32'(out_ch_b), 32'h2);
        check("b_rr_data", 32'(out_data_b), 32'h5);
        in_valid_b = 3'b011;
        #1;
        check("b_wrap2_ready", 32'(in_ready_b), 32'h1);
        tick();
        check("b_wrap2_ch", 32'(out_ch_b), 32'h0);
        mode_b = 1'b0; sel_b = 2'd3; in_valid_b = 3'b111;
        #1;
        check("b_oor_ready", 32'(in_ready_b), 32'h0);
        tick();
        check("b_oor_valid", 32'(out_valid_b), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
